// File: rtl/select_down_counter.sv
// rtl/select_down_counter.sv - loadable dual down-counter, channel 1 prescaled by DIV
module select_down_counter #(
  parameter int WIDTH = 64,
  parameter int DIV   = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Slt,
  input  logic             En,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Count0,
  output logic [WIDTH-1:0] Count1,
  output logic             Zero0,
  output logic             Zero1,
  output logic             Done0,
  output logic             Done1
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] prescaler;
  logic          run0;
  logic          run1;
  logic          tick1;

  assign run0  = !Load && En && !Slt && (Count0 != '0);
  assign run1  = !Load && En &&  Slt && (Count1 != '0);
  assign tick1 = run1 && (prescaler == PRE_LAST);

  assign Zero0 = (Count0 == '0);
  assign Zero1 = (Count1 == '0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Count0 <= '0;
    end else if (Load && !Slt) begin
      Count0 <= Din;
    end else if (run0) begin
      Count0 <= Count0 - 1'b1;
    end
  end

  // The prescaler is owned by channel 1 and freezes once Count1 reaches zero.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Count1    <= '0;
      prescaler <= '0;
    end else if (Load && Slt) begin
      Count1    <= Din;
      prescaler <= '0;
    end else if (run1) begin
      prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
      if (tick1) begin
        Count1 <= Count1 - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Done0 <= 1'b0;
      Done1 <= 1'b0;
    end else begin
      Done0 <= run0  && (Count0 == WIDTH'(1));
      Done1 <= tick1 && (Count1 == WIDTH'(1));
    end
  end

endmodule

// File: tb/tb_select_down_counter.sv
// tb/tb_select_down_counter.sv - scoreboard bench for select_down_counter
module tb_select_down_counter;

  localparam int WIDTH = 64;
  localparam int DIV   = 4;

  logic             Clk;
  logic             Reset;
  logic             Load;
  logic             Slt;
  logic             En;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Count0;
  logic [WIDTH-1:0] Count1;
  logic             Zero0;
  logic             Zero1;
  logic             Done0;
  logic             Done1;

  select_down_counter #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Load  (Load),
    .Slt   (Slt),
    .En    (En),
    .Din   (Din),
    .Count0(Count0),
    .Count1(Count1),
    .Zero0 (Zero0),
    .Zero1 (Zero1),
    .Done0 (Done0),
    .Done1 (Done1)
  );

  typedef struct {
    int               id;
    logic [WIDTH-1:0] c0;
    logic [WIDTH-1:0] c1;
    logic             d0;
    logic             d1;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;
  event sample_now;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Monitor: every pending expectation is compared when outputs are stable.
  initial begin
    exp_t e;
    logic ez0;
    logic ez1;
    forever begin
      @(negedge Clk or sample_now);
      while (q.size() > 0) begin
        e = q.pop_front();
        ez0 = (e.c0 == '0);
        ez1 = (e.c1 == '0);
        checks++;
        if (Count0 !== e.c0 || Count1 !== e.c1 || Zero0 !== ez0 || Zero1 !== ez1 ||
            Done0 !== e.d0 || Done1 !== e.d1) begin
          errors++;
          $display("FAIL step%0d: got c0=%0h c1=%0h z0=%b z1=%b d0=%b d1=%b, want c0=%0h c1=%0h z0=%b z1=%b d0=%b d1=%b",
                   e.id, Count0, Count1, Zero0, Zero1, Done0, Done1,
                   e.c0, e.c1, ez0, ez1, e.d0, e.d1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [WIDTH-1:0] c0, input logic [WIDTH-1:0] c1,
                      input logic d0, input logic d1);
    exp_t e;
    step_id++;
    e.id = step_id;
    e.c0 = c0;
    e.c1 = c1;
    e.d0 = d0;
    e.d1 = d1;
    q.push_back(e);
  endtask

  task automatic step(input logic ld, input logic sl, input logic en_i,
                      input logic [WIDTH-1:0] din_i,
                      input logic [WIDTH-1:0] c0, input logic [WIDTH-1:0] c1,
                      input logic d0, input logic d1);
    Load = ld;
    Slt  = sl;
    En   = en_i;
    Din  = din_i;
    @(posedge Clk);
    push(c0, c1, d0, d1);
    @(negedge Clk);
  endtask

  initial begin
    logic [WIDTH-1:0] ones;
    ones  = '1;
    Reset = 1'b0;
    Load  = 1'b0;
    Slt   = 1'b0;
    En    = 1'b0;
    Din   = '0;
    #2;
    push(0, 0, 0, 0);
    ->sample_now;
    @(negedge Clk);
    Reset = 1'b1;

    // 1: asynchronous reset mid-count
    step(1, 0, 0, 5, 5, 0, 0, 0);
    #2 Reset = 1'b0;
    #1 push(0, 0, 0, 0);
    ->sample_now;
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) step(0, 0, 1, 0, 0, 0, 0, 0);

    // 2: channel 0 countdown and saturation
    step(1, 0, 0, 3, 3, 0, 0, 0);
    step(0, 0, 1, 0, 2, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);

    // 3: channel 1 prescaled countdown
    step(1, 1, 0, 2, 0, 2, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0, 2, 0, 0);
    step(0, 1, 1, 0, 0, 1, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0);

    // 4: prescaler kept across idle and channel-0 cycles
    step(1, 1, 0, 5, 0, 5, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0, 5, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0, 5, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0, 5, 0, 0);
    step(0, 1, 1, 0, 0, 4, 0, 0);

    // 5: Load wins over En and clears the prescaler
    repeat (3) step(0, 1, 1, 0, 0, 4, 0, 0);
    step(1, 1, 1, 7, 0, 7, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0, 7, 0, 0);
    step(0, 1, 1, 0, 0, 6, 0, 0);

    // 6: loading zero gives no Done, counts stay at zero
    step(1, 0, 0, 1, 1, 6, 0, 0);
    step(1, 0, 1, 0, 0, 6, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (5) step(0, 1, 1, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0, 0, 0, 0);

    // all-ones load counts down normally
    step(1, 0, 0, ones, ones, 0, 0, 0);
    step(0, 0, 1, 0, ones - 1, 0, 0, 0);
    step(1, 1, 0, ones, ones - 1, ones, 0, 0);
    repeat (3) step(0, 1, 1, 0, ones - 1, ones, 0, 0);
    step(0, 1, 1, 0, ones - 1, ones - 1, 0, 0);

    repeat (2) @(negedge Clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
